// File: rtl/pkt_buf_pkg.sv
// pkt_buf_pkg: shared FSM states, slot metadata and width helpers for the packet buffer
package pkt_buf_pkg;
   localparam int LEN_W = 16;
   localparam int BV_MAX = 64;
   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_e;
   typedef enum logic {R_IDLE, R_BUSY} r_state_e;
   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [BV_MAX-1:0] last_bv;
      logic committed;
   } slot_meta_t;
   function automatic int id_w(input int n);
      return $clog2(n);
   endfunction
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/pkt_buf_if.sv
// pkt_buf_if: write/read packet bus between ingress, buffer controller and egress
interface pkt_buf_if #(
   parameter int DATA_W = 32,
   parameter int SLOT_CNT = 16
);
   localparam int ID_W = pkt_buf_pkg::id_w(SLOT_CNT);
   localparam int CNT_W = pkt_buf_pkg::cnt_w(SLOT_CNT);
   localparam int BV_W = DATA_W / 8;
   logic [DATA_W-1:0] data_in;
   logic [BV_W-1:0] byte_valid;
   logic wen;
   logic w_last_pkt;
   logic w_ready;
   logic [ID_W-1:0] id_out;
   logic id_valid;
   logic w_drop;
   logic ren;
   logic [ID_W-1:0] r_id_in;
   logic [DATA_W-1:0] data_out;
   logic [BV_W-1:0] r_byte_valid;
   logic r_valid;
   logic r_last_pkt;
   logic r_err;
   logic par_err;
   logic [CNT_W-1:0] free_cnt;
   modport master (
      output data_in, byte_valid, wen, w_last_pkt, ren, r_id_in,
      input w_ready, id_out, id_valid, w_drop, data_out, r_byte_valid, r_valid, r_last_pkt, r_err, par_err, free_cnt
   );
   modport slave (
      input data_in, byte_valid, wen, w_last_pkt, ren, r_id_in,
      output w_ready, id_out, id_valid, w_drop, data_out, r_byte_valid, r_valid, r_last_pkt, r_err, par_err, free_cnt
   );
endinterface

// File: rtl/pkt_buf_free_list.sv
// pkt_buf_free_list: circular FIFO of free slot IDs, one pop and up to two pushes per cycle
module pkt_buf_free_list import pkt_buf_pkg::*; #(
   parameter int SLOT_CNT = 16,
   localparam int ID_W = id_w(SLOT_CNT),
   localparam int CNT_W = cnt_w(SLOT_CNT)
) (
   input logic CLK,
   input logic reset,
   input logic pop,
   input logic push_a,
   input logic [ID_W-1:0] id_a,
   input logic push_b,
   input logic [ID_W-1:0] id_b,
   output logic [ID_W-1:0] head_id,
   output logic [CNT_W-1:0] count
);
   logic [ID_W-1:0] fifo [SLOT_CNT];
   logic [ID_W-1:0] head, tail;
   assign head_id = fifo[head];
   // list starts full with IDs in order; pushes land at tail, tail+1
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SLOT_CNT; i++) fifo[i] <= ID_W'(i);
         head <= '0;
         tail <= '0;
         count <= CNT_W'(SLOT_CNT);
      end else begin
         if (push_a) fifo[tail] <= id_a;
         if (push_b) fifo[tail + ID_W'(push_a)] <= id_b;
         head <= head + ID_W'(pop);
         tail <= tail + ID_W'(push_a) + ID_W'(push_b);
         count <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
      end
   end
endmodule

// File: rtl/pkt_buf_ctrl.sv
// pkt_buf_ctrl: slot-based packet buffer; define PKT_BUF_PARITY_EN for per-byte parity storage/check
module pkt_buf_ctrl import pkt_buf_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int SLOT_CNT = 16,
   parameter int SLOT_WORDS = 64
) (
   input logic CLK,
   input logic reset,
   pkt_buf_if.slave bus
);
   localparam int ID_W = id_w(SLOT_CNT);
   localparam int CNT_W = cnt_w(SLOT_CNT);
   localparam int WA_W = $clog2(SLOT_WORDS);
   localparam int BV_W = DATA_W / 8;
   localparam int AW = ID_W + WA_W;
   localparam int DEPTH = SLOT_CNT * SLOT_WORDS;
   w_state_e w_state, w_next;
   r_state_e r_state, r_next;
   slot_meta_t meta [SLOT_CNT];
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ID_W-1:0] head_id, cur_id, rd_id, w_id;
   logic [CNT_W-1:0] free_cnt;
   logic [WA_W:0] w_cnt;
   logic [WA_W-1:0] rd_ptr, w_word;
   logic [AW-1:0] waddr, raddr;
   logic have_free, pop, mem_we, ovf, commit, drop_now, accept, rd_last, r_rej;

   pkt_buf_free_list #(.SLOT_CNT(SLOT_CNT)) u_free_list (
      .CLK(CLK), .reset(reset), .pop(pop),
      .push_a(rd_last), .id_a(rd_id),
      .push_b(ovf), .id_b(cur_id),
      .head_id(head_id), .count(free_cnt)
   );

   assign have_free = free_cnt != '0;
   assign bus.free_cnt = free_cnt;
   assign bus.w_ready = have_free | (w_state == W_FILL);

   // write FSM state register
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) w_state <= W_IDLE;
      else w_state <= w_next;
   end

   // write FSM next state; a last word always returns to idle
   always_comb begin
      w_next = w_state;
      if (w_state == W_IDLE) w_next = (bus.wen && !bus.w_last_pkt) ? (have_free ? W_FILL : W_DROP) : W_IDLE;
      else if (bus.wen && bus.w_last_pkt) w_next = W_IDLE;
      else if (ovf) w_next = W_DROP;
   end

   // write FSM outputs: word 0 goes to the freshly popped slot, later words to cur_id
   always_comb begin
      ovf = w_state == W_FILL && bus.wen && w_cnt == (WA_W+1)'(SLOT_WORDS);
      pop = w_state == W_IDLE && bus.wen && have_free;
      mem_we = pop || (w_state == W_FILL && bus.wen && !ovf);
      w_id = pop ? head_id : cur_id;
      w_word = pop ? '0 : w_cnt[WA_W-1:0];
      waddr = {w_id, w_word};
      commit = mem_we && bus.w_last_pkt;
      drop_now = bus.wen && bus.w_last_pkt && ((w_state == W_IDLE && !have_free) || w_state == W_DROP || ovf);
   end

   // write-side datapath and result pulses
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         cur_id <= '0;
         w_cnt <= '0;
         bus.id_valid <= 1'b0;
         bus.id_out <= '0;
         bus.w_drop <= 1'b0;
      end else begin
         if (pop) cur_id <= head_id;
         w_cnt <= pop ? (WA_W+1)'(1) : mem_we ? w_cnt + (WA_W+1)'(1) : w_cnt;
         bus.id_valid <= commit;
         if (commit) bus.id_out <= w_id;
         bus.w_drop <= drop_now;
      end
   end

   // packet storage, dual-port: write here, registered read in the read pipeline
   always_ff @(posedge CLK) begin
      if (mem_we) mem[waddr] <= bus.data_in;
   end

   // slot metadata: set on commit, committed cleared once the packet has been read out
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SLOT_CNT; i++) meta[i] <= '0;
      end else begin
         if (commit) meta[w_id] <= '{len: pop ? LEN_W'(1) : LEN_W'(w_cnt) + LEN_W'(1), last_bv: BV_MAX'(bus.byte_valid), committed: 1'b1};
         if (rd_last) meta[rd_id].committed <= 1'b0;
      end
   end

   // read FSM state register
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) r_state <= R_IDLE;
      else r_state <= r_next;
   end

   // read FSM next state
   always_comb begin
      r_next = r_state == R_IDLE ? (accept ? R_BUSY : R_IDLE) : (rd_last ? R_IDLE : R_BUSY);
   end

   // read FSM outputs: accept only committed IDs while idle, everything else is rejected
   always_comb begin
      accept = bus.ren && r_state == R_IDLE && meta[bus.r_id_in].committed;
      rd_last = r_state == R_BUSY && LEN_W'(rd_ptr) + LEN_W'(1) == meta[rd_id].len;
      r_rej = bus.ren && !accept;
      raddr = {rd_id, rd_ptr};
   end

   // read pipeline: one address per cycle, data and markers one cycle later
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         rd_id <= '0;
         rd_ptr <= '0;
         bus.r_valid <= 1'b0;
         bus.r_last_pkt <= 1'b0;
         bus.r_err <= 1'b0;
         bus.data_out <= '0;
         bus.r_byte_valid <= '0;
      end else begin
         if (accept) rd_id <= bus.r_id_in;
         rd_ptr <= accept ? '0 : r_state == R_BUSY ? rd_ptr + WA_W'(1) : rd_ptr;
         bus.r_valid <= r_state == R_BUSY;
         bus.r_last_pkt <= rd_last;
         bus.r_err <= r_rej;
         if (r_state == R_BUSY) begin
            bus.data_out <= mem[raddr];
            bus.r_byte_valid <= rd_last ? BV_W'(meta[rd_id].last_bv) : '1;
         end
      end
   end

`ifdef PKT_BUF_PARITY_EN
   logic [BV_W-1:0] pmem [DEPTH];
   logic [BV_W-1:0] w_par, d_par, r_par;

   // even parity per byte of the incoming word and of the word being returned
   always_comb begin
      for (int i = 0; i < BV_W; i++) begin
         w_par[i] = ^bus.data_in[8*i +: 8];
         d_par[i] = ^bus.data_out[8*i +: 8];
      end
   end

   // parity bits travel alongside the data words
   always_ff @(posedge CLK) begin
      if (mem_we) pmem[waddr] <= w_par;
   end

   // stored parity read in step with data_out
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) r_par <= '0;
      else if (r_state == R_BUSY) r_par <= pmem[raddr];
   end

   assign bus.par_err = bus.r_valid & |(bus.r_byte_valid & (d_par ^ r_par));
`else
   assign bus.par_err = 1'b0;
`endif
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// tb_pkt_buf_ctrl: directed checks of write/commit, read-back, free list exhaustion, overflow, read errors and reset
module tb_pkt_buf_ctrl;
   logic CLK = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   int seen;

   always #5 CLK = ~CLK;

   pkt_buf_if #(.DATA_W(32), .SLOT_CNT(16)) bus ();

   pkt_buf_ctrl #(.DATA_W(32), .SLOT_CNT(16), .SLOT_WORDS(64)) dut (
      .CLK(CLK),
      .reset(reset),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_w(input logic wen, input logic last, input logic [31:0] d, input logic [3:0] bv);
      bus.wen = wen;
      bus.w_last_pkt = last;
      bus.data_in = d;
      bus.byte_valid = bv;
   endtask

   initial begin
      drive_w(0, 0, 0, 0);
      bus.ren = 0;
      bus.r_id_in = 0;
      tick();
      tick();
      check("rst_free_cnt", bus.free_cnt, 16);
      check("rst_w_ready", bus.w_ready, 1);
      check("rst_id_valid", bus.id_valid, 0);
      check("rst_id_out", bus.id_out, 0);
      check("rst_r_valid", bus.r_valid, 0);
      check("rst_data_out", bus.data_out, 0);
      check("rst_par_err", bus.par_err, 0);
      reset = 0;

      drive_w(1, 0, 32'hdeadface, 4'hf);
      tick();
      drive_w(1, 0, 32'h01234567, 4'hf);
      tick();
      drive_w(1, 1, 32'h000089ab, 4'h3);
      tick();
      drive_w(0, 0, 0, 0);
      check("p0_id_valid", bus.id_valid, 1);
      check("p0_id_out", bus.id_out, 0);
      check("p0_free_cnt", bus.free_cnt, 15);
      tick();
      check("p0_id_pulse_end", bus.id_valid, 0);

      bus.ren = 1;
      bus.r_id_in = 0;
      tick();
      bus.ren = 0;
      check("rd0_latency", bus.r_valid, 0);
      tick();
      check("rd0_w0_valid", bus.r_valid, 1);
      check("rd0_w0_data", bus.data_out, 32'hdeadface);
      check("rd0_w0_bv", bus.r_byte_valid, 4'hf);
      check("rd0_w0_last", bus.r_last_pkt, 0);
      tick();
      check("rd0_w1_data", bus.data_out, 32'h01234567);
      check("rd0_w1_bv", bus.r_byte_valid, 4'hf);
      check("rd0_w1_last", bus.r_last_pkt, 0);
      tick();
      check("rd0_w2_valid", bus.r_valid, 1);
      check("rd0_w2_data", bus.data_out, 32'h000089ab);
      check("rd0_w2_bv", bus.r_byte_valid, 4'h3);
      check("rd0_w2_last", bus.r_last_pkt, 1);
      check("rd0_par_err", bus.par_err, 0);
      check("rd0_free_cnt", bus.free_cnt, 16);
      tick();
      check("rd0_done", bus.r_valid, 0);

      bus.ren = 1;
      bus.r_id_in = 5;
      tick();
      bus.ren = 0;
      check("err_uncommitted", bus.r_err, 1);
      check("err_uncommitted_rv", bus.r_valid, 0);
      tick();
      check("err_pulse_end", bus.r_err, 0);
      check("err_no_rv", bus.r_valid, 0);

      drive_w(1, 0, 32'ha0, 4'hf);
      tick();
      drive_w(1, 0, 32'ha1, 4'hf);
      tick();
      drive_w(1, 1, 32'ha2, 4'hf);
      tick();
      drive_w(0, 0, 0, 0);
      check("p1_id_out", bus.id_out, 1);
      bus.ren = 1;
      bus.r_id_in = 1;
      tick();
      tick();
      bus.ren = 0;
      check("err_busy", bus.r_err, 1);
      check("busy_w0_data", bus.data_out, 32'ha0);
      tick();
      check("busy_err_end", bus.r_err, 0);
      check("busy_w1_data", bus.data_out, 32'ha1);
      tick();
      check("busy_w2_last", bus.r_last_pkt, 1);
      tick();
      check("busy_no_extra_rv", bus.r_valid, 0);
      check("busy_free_cnt", bus.free_cnt, 16);

      for (int i = 0; i < 16; i++) begin
         drive_w(1, 1, i, 4'hf);
         tick();
         check("fill_id_valid", bus.id_valid, 1);
         check("fill_id_out", bus.id_out, (i + 2) % 16);
      end
      check("full_free_cnt", bus.free_cnt, 0);
      check("full_w_ready", bus.w_ready, 0);
      drive_w(1, 1, 32'h99, 4'hf);
      tick();
      drive_w(0, 0, 0, 0);
      check("full_w_drop", bus.w_drop, 1);
      check("full_no_id", bus.id_valid, 0);
      tick();
      check("full_drop_end", bus.w_drop, 0);

      bus.ren = 1;
      bus.r_id_in = 5;
      tick();
      bus.ren = 0;
      tick();
      check("rd5_valid", bus.r_valid, 1);
      check("rd5_data", bus.data_out, 3);
      check("rd5_last", bus.r_last_pkt, 1);
      check("rd5_bv", bus.r_byte_valid, 4'hf);
      check("rd5_free_cnt", bus.free_cnt, 1);

      seen = 0;
      for (int k = 0; k < 65; k++) begin
         drive_w(1, k == 64, k, 4'hf);
         tick();
         if (k == 0) begin
            check("ovf_free_cnt_mid", bus.free_cnt, 0);
            check("ovf_w_ready_fill", bus.w_ready, 1);
         end
         if (k < 64) seen += int'(bus.id_valid) + int'(bus.w_drop);
      end
      drive_w(0, 0, 0, 0);
      check("ovf_no_early_pulse", seen, 0);
      check("ovf_w_drop", bus.w_drop, 1);
      check("ovf_no_id", bus.id_valid, 0);
      check("ovf_free_cnt", bus.free_cnt, 1);
      tick();

      drive_w(1, 0, 32'h11, 4'hf);
      tick();
      drive_w(1, 0, 32'h22, 4'hf);
      tick();
      check("mid_free_cnt", bus.free_cnt, 0);
      reset = 1;
      drive_w(0, 0, 0, 0);
      #2;
      check("arst_free_cnt", bus.free_cnt, 16);
      check("arst_w_ready", bus.w_ready, 1);
      check("arst_id_out", bus.id_out, 0);
      check("arst_data_out", bus.data_out, 0);
      check("arst_r_valid", bus.r_valid, 0);
      check("arst_w_drop", bus.w_drop, 0);
      tick();
      reset = 0;
      drive_w(1, 1, 32'h55, 4'hf);
      tick();
      drive_w(0, 0, 0, 0);
      check("post_rst_id_valid", bus.id_valid, 1);
      check("post_rst_id_out", bus.id_out, 0);
      check("post_rst_free_cnt", bus.free_cnt, 15);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pkt_buf_ctrl.md
Name: pkt_buf_ctrl

Overview:
Parametrised packet buffer controller, the successor to the single-configuration memory controller. It stores whole packets into fixed-size slots of an internal synchronous RAM and returns a slot ID per packet. Packets are read back by ID with byte-valid and last markers. Slots are recycled through a hardware free list. It sits between the packet ingress (parser front end) and the header/egress stages.

Parameters:
DATA_W, 32, data bus width in bits (multiple of 8)
SLOT_CNT, 16, number of packet slots (power of 2, >=2)
SLOT_WORDS, 64, maximum words per packet slot (power of 2)

Ports:
CLK  in  1  clock
reset  in  1  asynchronous, active-high reset
data_in  in  DATA_W  write data word
byte_valid  in  DATA_W/8  valid bytes of data_in (contiguous from LSB; only last word may be partial)
wen  in  1  write strobe, one word per cycle
w_last_pkt  in  1  marks final word of packet (qualified by wen)
w_ready  out  1  a free slot exists or a packet is in progress
id_out  out  $clog2(SLOT_CNT)  slot ID of committed packet
id_valid  out  1  one-cycle pulse, id_out valid
w_drop  out  1  one-cycle pulse, packet discarded
ren  in  1  read request pulse
r_id_in  in  $clog2(SLOT_CNT)  slot ID to read
data_out  out  DATA_W  read data
r_byte_valid  out  DATA_W/8  valid bytes of data_out
r_valid  out  1  data_out valid
r_last_pkt  out  1  final word of packet (with r_valid)
r_err  out  1  one-cycle pulse, read request rejected
par_err  out  1  parity error on current read word (see Optional Feature)
free_cnt  out  $clog2(SLOT_CNT)+1  number of free slots

Behaviour:
- Reset (async, any time): free list holds IDs 0..SLOT_CNT-1 in order; all slots marked uncommitted; both FSMs idle. free_cnt=SLOT_CNT; w_ready=1; all pulses, r_valid, r_last_pkt, par_err, data_out, r_byte_valid, id_out = 0. An in-flight packet is lost and its slot returns to the free list.
- Write FSM W_IDLE/W_FILL/W_DROP:
  - W_IDLE with wen and free_cnt>0: pop ID, write word 0, go to W_FILL; or stay in W_IDLE if w_last_pkt is set (single-word packet).
  - W_IDLE with wen and free_cnt=0: go to W_DROP; or, if w_last_pkt is set, pulse w_drop next cycle.
  - W_FILL: each wen writes the next word address. On wen&w_last_pkt: store length (words) and last byte_valid in slot metadata, mark committed, pulse id_valid with id_out the following cycle, return to W_IDLE.
  - W_FILL overflow (wen when word count=SLOT_WORDS): go to W_DROP and push the slot back to the free list.
  - W_DROP: ignore data. On wen&w_last_pkt, pulse w_drop next cycle and go to W_IDLE.
  - wen=0 cycles inside a packet are idle gaps.
- Read FSM R_IDLE/R_BUSY:
  - ren in R_IDLE with a committed r_id_in: go to R_BUSY and issue RAM reads, one address per cycle.
  - data_out/r_valid appear 1 cycle after each address; first word is 2 cycles after ren.
  - r_byte_valid is all ones except the last word, which uses the stored value. r_last_pkt accompanies the last word.
  - After the last word: clear committed, push ID to free list, return to R_IDLE.
  - ren with an uncommitted ID, or while R_BUSY: ignored, r_err pulse next cycle.
- Simultaneous pop (write) and push (read/drop) in one cycle: both take effect, free_cnt unchanged. The RAM is dual-port, so write and read never stall each other.
- w_ready = (free_cnt>0) | (state==W_FILL).

Optional Feature:
PKT_BUF_PARITY_EN: when defined, stores one even-parity bit per byte alongside the RAM data and checks it on read. par_err is asserted with r_valid for any mismatching valid byte. When undefined, no parity storage is built and par_err is tied to 0.

Decomposition:
- pkt_buf_pkg: write and read state enums, ID_W/CNT_W derivation functions, and the slot metadata struct (len, last_bv, committed).
- Sub-module pkt_buf_free_list: circular FIFO of IDs with simultaneous push/pop, reset-initialised to 0..SLOT_CNT-1, with count output.

Test Plan:
- After reset, write 3 words (0xdeadface, 0x01234567, 0x89ab with byte_valid 4'h3 and w_last_pkt) -> id_valid pulse with id_out=0, free_cnt=15.
- ren with r_id_in=0 -> r_valid on 3 consecutive cycles starting 2 cycles after ren, data matches, r_byte_valid f,f,3, r_last_pkt on the third word; free_cnt returns to 16.
- Write 16 one-word packets, then a 17th -> w_ready=0 after the 16th, 17th gives w_drop pulse, no id_valid.
- 65-word packet with SLOT_WORDS=64 -> w_drop on last, no id_valid, free_cnt unchanged.
- ren on uncommitted ID 5, then ren during an active read -> r_err pulse each time, no r_valid.
- Assert reset mid-write after 2 words -> all outputs 0, free_cnt=16; the next packet receives ID 0.
